tube_scan_driver: RTL and testbench

//  Downstream display stage. Takes display_hour/min/sec (7-bit binary, 0..99 each)

---
 rtl/tube_scan_driver.sv | 192 +++++++++++++++++++
 tb/tb_tube_scan_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tube_scan_driver.sv
// Scans hh.mm.ss across a 6-digit common-segment 7-seg tube: binary -> 2 decimal digits -> segment pattern.
// Latency: seg/dig_sel are registered one clk after the internal scan state. Input values are adopted at frame start.
// Backpressure: none. The display free-runs, and blink gating is applied live per slot.
module tube_scan_driver #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 8,
  parameter int BLINK_DIV      = 250000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] display_hour,
  input  logic [6:0] display_min,
  input  logic [6:0] display_sec,
  input  logic       blink_hour,
  input  logic       blink_min,
  output logic [7:0] seg,
  output logic [5:0] dig_sel
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Unlit / deselected levels after polarity is applied
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [5:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

  localparam logic [6:0] DASH = 7'h40;

  // Scan state
  logic [SW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic          scan_wrap;
  logic          frame_wrap;

  // Frame snapshot of the displayed values
  logic [6:0]    hour_q;
  logic [6:0]    min_q;
  logic [6:0]    sec_q;
  logic          snap_pending;
  logic [6:0]    hour_v;
  logic [6:0]    min_v;
  logic [6:0]    sec_v;

  // Blink timebase
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Per-slot decode
  logic [6:0]    pair_val;
  logic [7:0]    pair_dec;
  logic [3:0]    digit_val;
  logic [6:0]    glyph;
  logic          dp_on;
  logic          slot_blank;
  logic          pair_blinked;
  logic [7:0]    seg_nxt;
  logic [5:0]    dig_nxt;

  // Binary 0..99 to {tens, units} by bounded repeated subtraction of ten.
  function automatic logic [7:0] to_dec(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Decimal digit to active-high {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = DASH;
    endcase
    return p;
  endfunction

  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_wrap && (idx == 3'd5);

  // The first cycle after reset shows the live inputs so that frame 0 never displays the cleared snapshot.
  assign hour_v = snap_pending ? display_hour : hour_q;
  assign min_v  = snap_pending ? display_min  : min_q;
  assign sec_v  = snap_pending ? display_sec  : sec_q;

  // Digit slot advance: scan_cnt wraps every SCAN_DIV cycles, and idx walks 0..5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Capture the three values once per frame so that a digit pair never tears mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_pending <= 1'b1;
      hour_q       <= 7'd0;
      min_q        <= 7'd0;
      sec_q        <= 7'd0;
    end else begin
      snap_pending <= 1'b0;
      if (snap_pending || frame_wrap) begin
        hour_q <= display_hour;
        min_q  <= display_min;
        sec_q  <= display_sec;
      end
    end
  end

  // Free-running blink half-period timer. The phase flips on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Pick the value pair for the current slot, then select the tens or units digit.
  always_comb begin
    pair_val = hour_v;
    case (idx)
      3'd0, 3'd1: pair_val = sec_v;
      3'd2, 3'd3: pair_val = min_v;
      default:    pair_val = hour_v;
    endcase
    pair_dec  = to_dec(pair_val);
    digit_val = idx[0] ? pair_dec[7:4] : pair_dec[3:0];
    // Out-of-range values show a dash on both digits of the pair.
    glyph     = (pair_val >= 7'd100) ? DASH : enc7(digit_val);
    dp_on     = (idx == 3'd2) || (idx == 3'd4);
  end

  // Slot gating: a blank lead-in per slot, plus set-mode blinking of the hour/min pairs.
  always_comb begin
    slot_blank   = (scan_cnt < BLANK_END);
    pair_blinked = blink_phase &&
                   ((blink_hour && (idx == 3'd4 || idx == 3'd5)) ||
                    (blink_min  && (idx == 3'd2 || idx == 3'd3)));
    seg_nxt = 8'h00;
    dig_nxt = 6'h00;
    if (!slot_blank) begin
      dig_nxt = 6'b000001 << idx;
      if (!pair_blinked) begin
        seg_nxt = {dp_on, glyph};
      end
    end
  end

  // Register the outputs and apply the pin polarity at the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg     <= (SEG_ACTIVE_LOW != 0) ? ~seg_nxt : seg_nxt;
      dig_sel <= (DIG_ACTIVE_LOW != 0) ? ~dig_nxt : dig_nxt;
    end
  end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Bench for tube_scan_driver with SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=64, and active-low pins.
// A cycle-count model predicts every output cycle. Directed checkpoints pin literal patterns.
// Inputs change just after the falling edge. Outputs are sampled on the falling edge.
module tb_tube_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] display_hour;
  logic [6:0] display_min;
  logic [6:0] display_sec;
  logic       blink_hour;
  logic       blink_min;
  logic [7:0] seg;
  logic [5:0] dig_sel;

  tube_scan_driver #(
    .SCAN_DIV      (4),
    .BLANK_CYC     (1),
    .BLINK_DIV     (64),
    .SEG_ACTIVE_LOW(1),
    .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .display_hour(display_hour),
    .display_min (display_min),
    .display_sec (display_sec),
    .blink_hour  (blink_hour),
    .blink_min   (blink_min),
    .seg         (seg),
    .dig_sel     (dig_sel)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: kk counts clock edges taken since reset release.
  int         kk = 0;
  int         m_pos, m_id, m_v;
  logic [7:0] m_pat;
  logic [6:0] f_hour = 7'd0;
  logic [6:0] f_min  = 7'd0;
  logic [6:0] f_sec  = 7'd0;
  logic [7:0] exp_seg = 8'hFF;
  logic [5:0] exp_dig = 6'h3F;

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Model: the output after the edge taken at count kk.
  // slot = kk/4, position in slot = kk%4, digit = slot%6, frame = kk/24, blink phase = (kk/64)%2.
  always @(posedge clk) begin
    if (!rst_n) begin
      kk      = 0;
      exp_seg = 8'hFF;
      exp_dig = 6'h3F;
    end else begin
      m_pos = kk % 4;
      m_id  = (kk / 4) % 6;
      if (m_pos < 1) begin
        exp_seg = 8'hFF;
        exp_dig = 6'h3F;
      end else begin
        m_v = (m_id < 2) ? int'(f_sec) : (m_id < 4) ? int'(f_min) : int'(f_hour);
        if (m_v >= 100) m_pat = 8'h40;
        else            m_pat = glyph((m_id % 2 == 0) ? (m_v % 10) : (m_v / 10));
        if (m_id == 2 || m_id == 4) m_pat = m_pat | 8'h80;
        if (((kk / 64) % 2 == 1) &&
            ((blink_hour && m_id >= 4) || (blink_min && (m_id == 2 || m_id == 3))))
          m_pat = 8'h00;
        exp_seg = ~m_pat;
        exp_dig = ~(6'(1 << m_id));
      end
      // Values seen at the frame's last edge (or at the first edge) are used for the next frame.
      if (kk == 0 || kk % 24 == 23) begin
        f_hour = display_hour;
        f_min  = display_min;
        f_sec  = display_sec;
      end
      kk++;
    end
  end

  // Compare the DUT against the model on every cycle.
  logic [7:0] c_seg;
  logic [5:0] c_dig;
  always @(negedge clk) begin
    c_seg = rst_n ? exp_seg : 8'hFF;
    c_dig = rst_n ? exp_dig : 6'h3F;
    vectors++;
    if (seg !== c_seg || dig_sel !== c_dig) begin
      miscompares++;
      $display("FAIL model k=%0d: seg=%h dig_sel=%h, required seg=%h dig_sel=%h",
               kk - 1, seg, dig_sel, c_seg, c_dig);
    end
  end

  task automatic chk(input string name, input logic [7:0] req_s, input logic [5:0] req_d);
    vectors++;
    if (seg !== req_s || dig_sel !== req_d) begin
      miscompares++;
      $display("FAIL %s: seg=%h dig_sel=%h, required seg=%h dig_sel=%h",
               name, seg, dig_sel, req_s, req_d);
    end
  endtask

  // Wait for the falling edge that follows edge k.
  task automatic goto(input int k);
    int b;
    b = 0;
    while (kk != k + 1 && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (kk != k + 1) begin
      vectors++;
      miscompares++;
      $display("FAIL goto_%0d: edge count=%0d, required %0d", k, kk, k + 1);
    end
  endtask

  task automatic at_k(input string name, input int k, input logic [7:0] s, input logic [5:0] d);
    goto(k);
    chk(name, s, d);
  endtask

  initial begin
    rst_n        = 1'b0;
    display_hour = 7'd12;
    display_min  = 7'd34;
    display_sec  = 7'd56;
    blink_hour   = 1'b0;
    blink_min    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", 8'hFF, 6'h3F);
    #1 rst_n = 1'b1;

    // First frame, 12.34.56
    at_k("d0_sec_units6", 1, 8'h82, 6'h3E);
    at_k("d1_sec_tens5", 5, 8'h92, 6'h3D);
    at_k("d2_min_units4_dp", 9, 8'h19, 6'h3B);
    at_k("d5_hour_tens1", 21, 8'hF9, 6'h1F);
    at_k("frame_wrap_blank", 24, 8'hFF, 6'h3F);
    at_k("frame_wrap_d0", 25, 8'h82, 6'h3E);

    // Change sec mid-frame (idx 2 of frame 1). It appears only from frame 2 onward.
    goto(33);
    display_sec = 7'd7;
    at_k("tearfree_d0_07", 49, 8'hF8, 6'h3E);
    at_k("tearfree_d1_07", 53, 8'hC0, 6'h3D);

    // Range test, adopted at frame 3 (k=72..95)
    goto(54);
    display_hour = 7'd100;
    display_min  = 7'd0;
    display_sec  = 7'd99;
    at_k("sec99_units", 73, 8'h90, 6'h3E);
    at_k("sec99_tens", 77, 8'h90, 6'h3D);
    at_k("min00_units_dp", 81, 8'h40, 6'h3B);
    at_k("min00_tens", 85, 8'hC0, 6'h37);
    at_k("hour100_dash_dp", 89, 8'h3F, 6'h2F);
    at_k("hour100_dash", 93, 8'hBF, 6'h1F);

    // Blink min. Phase 1 covers k=64..127 and 192..255.
    goto(95);
    display_hour = 7'd12;
    display_min  = 7'd45;
    display_sec  = 7'd56;
    blink_min    = 1'b1;
    at_k("blink_min_live", 105, 8'hFF, 6'h3B);
    at_k("blink_sec_unaff0", 121, 8'h82, 6'h3E);
    at_k("blink_sec_unaff1", 125, 8'h92, 6'h3D);
    at_k("blink_phase0_min", 129, 8'h12, 6'h3B);
    at_k("blink_ph1_d0", 193, 8'h82, 6'h3E);
    at_k("blink_ph1_d2", 201, 8'hFF, 6'h3B);
    at_k("blink_ph1_d3", 205, 8'hFF, 6'h37);
    at_k("blink_ph1_d4", 209, 8'h24, 6'h2F);
    blink_hour = 1'b1;
    at_k("blink_both_d5", 213, 8'hFF, 6'h1F);
    at_k("blink_both_d3", 229, 8'hFF, 6'h37);
    at_k("blink_both_d4", 233, 8'hFF, 6'h2F);
    at_k("blink_ph0_d4", 257, 8'h24, 6'h2F);
    at_k("blink_ph0_d5", 261, 8'hF9, 6'h1F);
    blink_hour = 1'b0;
    blink_min  = 1'b0;

    // Async reset while internal idx=3 and scan_cnt=2
    at_k("pre_reset_d3", 277, 8'h99, 6'h37);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_no_clk", 8'hFF, 6'h3F);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    at_k("restart_d0", 1, 8'h82, 6'h3E);
    at_k("restart_d1", 5, 8'h92, 6'h3D);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
